// File: rtl/shift_reg_n.sv
// -----------------------------------------------------------------------------
// shift_reg_n
//
// Purpose:
//   WIDTH-bit universal register. Each edge it can hold, parallel-load, shift
//   right/left, rotate right/left, arithmetic-shift right or clear. A serial
//   bit enters on logical shifts. Shift_Out is a registered copy of the bit
//   that most recently left the register.
//   With the burst engine built in, one Start runs Count consecutive shifts.
//
// Build option:
//   SHIFT_REG_N_BURST_EN - when defined, the burst engine (FSM, Start/Count,
//   Busy/Done) is present. When undefined, Start and Count are ignored,
//   Busy and Done are tied low, and only single-step En/Mode operation remains.
//
// Parameters:
//   WIDTH       - register width (>= 2)
//   RESET_VALUE - value of Out while Reset is asserted
//   CW          - width of Count, derived from WIDTH
//
// Ports:
//   Clk       in   rising-edge clock
//   Reset     in   asynchronous, active-high reset
//   En        in   single-step enable, applies Mode for one edge
//   Mode      in   000 hold, 001 load, 010 shr, 011 shl, 100 ror, 101 rol,
//                  110 asr, 111 clear
//   In        in   parallel load data
//   Shift_In  in   serial bit for logical shifts
//   Start     in   burst request (Mode and Count captured on the same edge)
//   Count     in   number of burst shifts
//   Out       out  register contents
//   Shift_Out out  bit shifted/rotated out on the most recent shift
//   Busy      out  burst in progress
//   Done      out  one-cycle burst-complete pulse
// -----------------------------------------------------------------------------
module shift_reg_n #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int unsigned     CW          = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] In,
  input  logic             Shift_In,
  input  logic             Start,
  input  logic [CW-1:0]    Count,
  output logic [WIDTH-1:0] Out,
  output logic             Shift_Out,
  output logic             Busy,
  output logic             Done
);

  // Applies one mode to the current value. Returns {shift_out, value}.
  function automatic logic [WIDTH:0] step(
    input logic [2:0]       mode,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] load_val,
    input logic             sin,
    input logic             so
  );
    logic [WIDTH-1:0] nxt;
    logic             so_n;
    nxt  = cur;
    so_n = so;
    case (mode)
      3'b001: nxt = load_val;
      3'b010: begin nxt = {sin, cur[WIDTH-1:1]};          so_n = cur[0];       end
      3'b011: begin nxt = {cur[WIDTH-2:0], sin};          so_n = cur[WIDTH-1]; end
      3'b100: begin nxt = {cur[0], cur[WIDTH-1:1]};       so_n = cur[0];       end
      3'b101: begin nxt = {cur[WIDTH-2:0], cur[WIDTH-1]}; so_n = cur[WIDTH-1]; end
      3'b110: begin nxt = {cur[WIDTH-1], cur[WIDTH-1:1]}; so_n = cur[0];       end
      3'b111: nxt = '0;
      default: ;  // hold
    endcase
    return {so_n, nxt};
  endfunction

  logic [WIDTH-1:0] out_q, out_d;
  logic             so_q, so_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      out_q <= RESET_VALUE;
      so_q  <= 1'b0;
    end else begin
      out_q <= out_d;
      so_q  <= so_d;
    end
  end

  assign Out       = out_q;
  assign Shift_Out = so_q;

`ifdef SHIFT_REG_N_BURST_EN

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    mode_q, mode_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          start_shifts;

  // Only the shift/rotate modes (010..110) with a non-zero count run a burst.
  assign start_shifts = (Mode >= 3'b010) && (Mode <= 3'b110) && (Count != '0);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      mode_q  <= 3'b000;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    rem_d         = rem_q;
    {so_d, out_d} = {so_q, out_q};
    case (state_q)
      ST_SHIFT: begin
        // Captured mode with live Shift_In; En, Start, Mode, Count ignored.
        {so_d, out_d} = step(mode_q, out_q, In, Shift_In, so_q);
        rem_d         = rem_q - CW'(1);
        state_d       = (rem_q == CW'(1)) ? ST_FINISH : ST_SHIFT;
      end
      default: begin  // ST_IDLE and ST_FINISH behave identically
        state_d = ST_IDLE;
        if (Start) begin
          mode_d  = Mode;
          rem_d   = Count;
          state_d = start_shifts ? ST_SHIFT : ST_FINISH;
        end else if (En) begin
          {so_d, out_d} = step(Mode, out_q, In, Shift_In, so_q);
        end
      end
    endcase
  end

  assign Busy = (state_q == ST_SHIFT);
  assign Done = (state_q == ST_FINISH);

`else

  logic unused_burst_inputs;
  assign unused_burst_inputs = ^{Start, Count};

  always_comb begin
    {so_d, out_d} = {so_q, out_q};
    if (En) begin
      {so_d, out_d} = step(Mode, out_q, In, Shift_In, so_q);
    end
  end

  assign Busy = 1'b0;
  assign Done = 1'b0;

`endif

endmodule

// File: tb/tb_shift_reg_n.sv
// -----------------------------------------------------------------------------
// tb_shift_reg_n
//
// Self-checking bench for shift_reg_n (WIDTH=8, RESET_VALUE=8'hA5). A
// behavioural model tracks the register as an integer value plus a count of
// pending burst shifts; every clock edge the DUT outputs are compared with it.
// Directed sequences follow the intended use cases, then random traffic runs.
// -----------------------------------------------------------------------------
module tb_shift_reg_n;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(W + 1);
  localparam logic [W-1:0] RV = 8'hA5;
`ifdef SHIFT_REG_N_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [2:0]    mode = 3'b000;
  logic [W-1:0]  din = '0;
  logic          sin = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] count = '0;
  logic [W-1:0]  dout;
  logic          so;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  shift_reg_n #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .Clk(clk), .Reset(rst), .En(en), .Mode(mode), .In(din),
    .Shift_In(sin), .Start(start), .Count(count),
    .Out(dout), .Shift_Out(so), .Busy(busy), .Done(done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [W-1:0] m_out;
  logic         m_so;
  logic [2:0]   m_mode;
  int           m_left;   // burst shifts still to perform
  logic         m_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_out  = RV;
    m_so   = 1'b0;
    m_mode = 3'b000;
    m_left = 0;
    m_done = 1'b0;
  endtask

  task automatic m_apply(input logic [2:0] md, input logic [W-1:0] ld, input logic s);
    case (md)
      3'd1: m_out = ld;
      3'd2: begin m_so = m_out[0];   m_out = (m_out >> 1) | (s ? 8'h80 : 8'h00); end
      3'd3: begin m_so = m_out[W-1]; m_out = (m_out << 1) | W'(s); end
      3'd4: begin m_so = m_out[0];   m_out = (m_out >> 1) | (m_out << (W - 1)); end
      3'd5: begin m_so = m_out[W-1]; m_out = (m_out << 1) | (m_out >> (W - 1)); end
      3'd6: begin m_so = m_out[0];   m_out = W'($signed(m_out) >>> 1); end
      3'd7: m_out = '0;
      default: ;
    endcase
  endtask

  task automatic m_edge();
    if (m_left > 0) begin
      m_apply(m_mode, din, sin);
      m_left--;
      m_done = (m_left == 0);
    end else begin
      m_done = 1'b0;
      if (BURST && start) begin
        m_mode = mode;
        if (mode >= 3'd2 && mode <= 3'd6 && count > 0) m_left = int'(count);
        else m_done = 1'b1;
      end else if (en) begin
        m_apply(mode, din, sin);
      end
    end
  endtask

  task automatic compare(input string tag);
    check({tag, ".out"},  32'(dout), 32'(m_out));
    check({tag, ".so"},   32'(so),   32'(m_so));
    check({tag, ".busy"}, 32'(busy), 32'(m_left > 0));
    check({tag, ".done"}, 32'(done), 32'(m_done));
  endtask

  // One clock edge: model advances with the inputs sampled, compare #1 later.
  task automatic cycle(input string tag);
    @(posedge clk);
    m_edge();
    #1;
    compare(tag);
  endtask

  // Reset asserted away from any edge; Out must change before the next edge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    m_reset();
    compare(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input logic e, input logic [2:0] md, input logic [W-1:0] d,
                       input logic s, input logic st, input logic [CW-1:0] c);
    en = e; mode = md; din = d; sin = s; start = st; count = c;
  endtask

  localparam logic [7:0] SERIAL = 8'b1011_0010;  // bits sent MSB first: 1,0,1,1,0,0,1,0

  initial begin
    logic [7:0] bits;
    bits = SERIAL;
    m_reset();

    // Reset
    async_reset("reset");
    check("reset_out_const", 32'(dout), 32'h0000_00A5);

    // Single steps
    drive(1, 3'b001, 8'b1001_0110, 0, 0, 0); cycle("load");
    drive(1, 3'b010, 8'h00, 1, 0, 0);        cycle("shr");
    check("shr_const", 32'(dout), 32'hCB);
    check("shr_so_const", 32'(so), 32'h0);
    drive(1, 3'b101, 8'h00, 0, 0, 0);        cycle("rol");
    check("rol_const", 32'(dout), 32'h97);
    check("rol_so_const", 32'(so), 32'h1);
    drive(1, 3'b110, 8'h00, 0, 0, 0);        cycle("asr");
    check("asr_const", 32'(dout), 32'hCB);
    drive(1, 3'b111, 8'h00, 0, 0, 0);        cycle("clr");
    check("clr_const", 32'(dout), 32'h00);
    drive(0, 3'b001, 8'h5A, 0, 0, 0);        cycle("en_low");

    // Burst rotate-left x3 with En held high (ignored while busy)
    drive(1, 3'b001, 8'h81, 0, 0, 0);        cycle("load81");
    drive(0, 3'b101, 8'h00, 0, 1, 4'd3);     cycle("b_start");
    drive(1, 3'b001, 8'hFF, 0, 0, 0);
    cycle("b_rol1");
`ifdef SHIFT_REG_N_BURST_EN
    check("b_rol1_const", 32'(dout), 32'h03);
`endif
    cycle("b_rol2");
    cycle("b_rol3");
`ifdef SHIFT_REG_N_BURST_EN
    check("b_rol3_const", 32'(dout), 32'h0C);
    check("b_done_const", 32'(done), 32'h1);
`endif
    drive(0, 3'b000, 8'h00, 0, 0, 0);        cycle("b_after");

    // Zero-count and non-shift-mode bursts
    drive(0, 3'b010, 8'h00, 0, 1, 4'd0);     cycle("z_start");
    drive(0, 3'b000, 8'h00, 0, 0, 0);        cycle("z_after");
    drive(0, 3'b001, 8'h55, 0, 1, 4'd5);     cycle("ld_start");
    drive(0, 3'b000, 8'h00, 0, 0, 0);        cycle("ld_after");

    // Reset in the middle of a 4-shift burst
    drive(0, 3'b011, 8'h00, 1, 1, 4'd4);     cycle("r_start");
    drive(0, 3'b000, 8'h00, 1, 0, 0);
    cycle("r_sh1");
    cycle("r_sh2");
    async_reset("r_abort");
    for (int i = 0; i < 3; i++) cycle("r_nodone");

    // Serial capture, then back-to-back Start in the Done cycle
    drive(0, 3'b010, 8'h00, 0, 1, 4'd8);     cycle("s_start");
    start = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      sin = bits[i];
      cycle("s_shift");
    end
`ifdef SHIFT_REG_N_BURST_EN
    check("s_capture_const", 32'(dout), 32'h4D);
`endif
    drive(0, 3'b100, 8'h00, 0, 1, 4'd2);     cycle("s_b2b");
    drive(0, 3'b000, 8'h00, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle("s_b2b_run");

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)), 8'($urandom),
            1'($urandom_range(1, 0)), ($urandom_range(9, 0) == 0),
            CW'($urandom_range(15, 0)));
      if ($urandom_range(199, 0) == 0) async_reset("rnd_reset");
      else cycle("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_reg_n.md
# shift_reg_n

Parametrised universal register: a WIDTH-bit register with per-cycle modes (hold, load, shift, rotate, arithmetic shift, clear) and a serial in/out bit. An optional burst engine performs Count consecutive shifts after a single Start. It is the general-purpose successor to the fixed 8-bit enable register and serves as the datapath register for serialisers, scroll buffers and multiply/divide helpers.

## Interface
- WIDTH, 8: register width, ≥ 2.
- RESET_VALUE, '0: value loaded into Out on Reset (WIDTH bits).
- CW, $clog2(WIDTH+1): width of Count; derived, not overridden.
- Clk  input  1  single clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high; clears all state immediately.
- En  input  1  single-step enable; applies Mode for one edge.
- Mode  input  3  operation select: 000 hold, 001 parallel load, 010 shift right, 011 shift left, 100 rotate right, 101 rotate left, 110 arithmetic shift right, 111 clear.
- In  input  WIDTH  parallel load data.
- Shift_In  input  1  serial bit entering on logical shifts (MSB for right, LSB for left).
- Start  input  1  burst request; Mode and Count are captured on the same edge.
- Count  input  CW  number of burst shifts.
- Out  output  WIDTH  register contents.
- Shift_Out  output  1  registered bit that left the register on the most recent shift or rotate.
- Busy  output  1  burst in progress.
- Done  output  1  one-cycle burst-complete pulse.

## Operation
- Reset values:
  - Out = RESET_VALUE.
  - Shift_Out = 0, Busy = 0, Done = 0.
  - FSM in IDLE; captured mode and remaining count cleared.
- Mode semantics per edge (W = WIDTH):
  - 010 shift right: Out = {Shift_In, Out[W-1:1]}, Shift_Out = Out[0].
  - 011 shift left: Out = {Out[W-2:0], Shift_In}, Shift_Out = Out[W-1].
  - 100 rotate right: Out = {Out[0], Out[W-1:1]}, Shift_Out = Out[0].
  - 101 rotate left: Out = {Out[W-2:0], Out[W-1]}, Shift_Out = Out[W-1].
  - 110 arithmetic shift right: Out = {Out[W-1], Out[W-1:1]}, Shift_Out = Out[0].
  - 001 load: Out = In. 111 clear: Out = 0. 000 hold: Out unchanged.
  - Shift_Out is unchanged by 000, 001 and 111.
- FSM states:
  - IDLE: En=1 applies Mode once. Start=1 captures Mode and Count.
    - Shift-class mode (010–110) with Count>0 → SHIFT, remaining = Count.
    - Non-shift mode or Count=0 → FINISH, register untouched.
  - SHIFT: every edge applies the captured mode, using the live Shift_In, and decrements remaining. When remaining = 1 → FINISH.
  - FINISH: behaves exactly like IDLE for En and Start, and also returns to IDLE (or re-enters SHIFT/FINISH on a new Start).
- Busy = (state == SHIFT). Done = (state == FINISH). Both are Moore outputs.
- Priority:
  - In IDLE/FINISH: Start over En.
  - In SHIFT: En and Start are ignored; Mode, Count and In changes have no effect.
- Reset asserted mid-burst aborts immediately: Out = RESET_VALUE, and no Done pulse follows.

## Timing
- Single step: En sampled at edge t → Out and Shift_Out valid after edge t (latency 1).
- Burst of k>0 shifts, Start sampled at edge t:
  - Shifts occur at edges t+1 … t+k.
  - Busy is high from after edge t to after edge t+k.
  - Done is high for the one cycle between edges t+k and t+k+1.
- Burst with k=0 or a non-shift mode: Done is high for the cycle after edge t; Busy is never asserted.
- Back-to-back: Start in the Done cycle is accepted, with no idle cycle required.
- Count is unrestricted up to 2^CW−1. k > WIDTH simply keeps shifting.

## Configuration
- SHIFT_REG_N_BURST_EN defined: burst engine, FSM, Busy and Done present as above.
- Not defined:
  - Start and Count are ignored.
  - Busy and Done are tied to 0.
  - Only single-step En/Mode operation remains, with identical single-step timing.

## Test plan
- Reset with RESET_VALUE=8'hA5 asserted asynchronously mid-cycle → Out=8'hA5 immediately; Shift_Out, Busy, Done = 0.
- Load 8'b1001_0110, then single steps:
  - shift right with Shift_In=1 → 8'b1100_1011, Shift_Out=0.
  - rotate left → 8'b1001_0111, Shift_Out=1.
  - arithmetic shift right → 8'b1100_1011, Shift_Out=1.
  - clear → 8'h00.
- Load 8'h81, Start with Mode=101 and Count=3 → Busy high 3 cycles; Out after the shifts = 8'h03, 8'h06, 8'h0C; Done pulses one cycle after the third shift; En asserted during Busy is ignored.
- Start with Count=0 → Done next cycle, Busy stays 0, Out unchanged. Start with Mode=001 and Count=5 → same, with no load performed.
- Start a Count=4 burst and assert Reset after 2 shifts → Out=RESET_VALUE, Busy=0, and no Done pulse.
- Serial capture: Start with Mode=010 and Count=8, driving Shift_In=1,0,1,1,0,0,1,0 on successive cycles → Out=8'b0100_1101 at Done. A new Start issued in the Done cycle is accepted.
